// File: rtl/bs_gnrtr_n_rbtr.sv
`default_nettype none
// ============================================================================
// Module   : bs_gnrtr_n_rbtr
// Purpose  : Per-bus round-robin arbiter that pops one packet from a pending
//            device and delivers it to its destination ID or broadcasts it.
// Revision : 1.0 - initial release
// ============================================================================
module bs_gnrtr_n_rbtr #(
    parameter int         BITS      = 1,
    parameter int         DRVRS     = 4,
    parameter int         PCKG_SZ   = 16,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [BITS-1:0][DRVRS-1:0]              pndng,
    input  logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_pop,
    output logic [BITS-1:0][DRVRS-1:0]              pop,
    output logic [BITS-1:0][DRVRS-1:0]              push,
    output logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_push
);

    localparam int c_id_w = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    for (genvar b = 0; b < BITS; b++) begin : g_bus
        state_t                         r_state;
        state_t                         w_state_nxt;
        logic [PCKG_SZ-1:0]             r_pkt;
        logic [PCKG_SZ-1:0]             w_pkt_nxt;
        logic [c_id_w-1:0]              r_src;
        logic [c_id_w-1:0]              w_src_nxt;
        logic [c_id_w-1:0]              r_last;
        logic [c_id_w-1:0]              w_last_nxt;
        logic [DRVRS-1:0]               r_pop;
        logic [DRVRS-1:0]               w_pop_nxt;
        logic [DRVRS-1:0]               r_push;
        logic [DRVRS-1:0]               w_push_nxt;
        logic [DRVRS-1:0][PCKG_SZ-1:0]  r_dpush;
        logic [DRVRS-1:0][PCKG_SZ-1:0]  w_dpush_nxt;
        logic                           w_found;
        logic [c_id_w-1:0]              w_win;
        logic [7:0]                     w_dest;

        assign w_dest = r_pkt[PCKG_SZ-1 -: 8];

        // Search starts just after the last granted device and wraps around.
        always_comb begin
            w_found = 1'b0;
            w_win   = '0;
            for (int k = 1; k <= DRVRS; k++) begin
                if (!w_found && pndng[b][(int'(r_last) + k) % DRVRS]) begin
                    w_found = 1'b1;
                    w_win   = c_id_w'((int'(r_last) + k) % DRVRS);
                end
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_pkt_nxt   = r_pkt;
            w_src_nxt   = r_src;
            w_last_nxt  = r_last;
            w_pop_nxt   = '0;
            w_push_nxt  = '0;
            w_dpush_nxt = r_dpush;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        w_pkt_nxt   = D_pop[b][w_win];
                        w_src_nxt   = w_win;
                        w_pop_nxt   = DRVRS'(1) << w_win;
                        w_state_nxt = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_dest == BROADCAST) begin
                        w_push_nxt = ~(DRVRS'(1) << r_src);
                    end else if ((int'(w_dest) < DRVRS) &&
                                 (int'(w_dest) != int'(r_src))) begin
                        w_push_nxt = DRVRS'(1) << w_dest;
                    end
                    // Invalid or self-addressed IDs leave the mask empty (dropped).
                    w_dpush_nxt = {DRVRS{r_pkt}};
                    w_last_nxt  = r_src;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_pkt   <= '0;
                r_src   <= '0;
                r_last  <= c_id_w'(DRVRS - 1);
                r_pop   <= '0;
                r_push  <= '0;
                r_dpush <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_pkt   <= w_pkt_nxt;
                r_src   <= w_src_nxt;
                r_last  <= w_last_nxt;
                r_pop   <= w_pop_nxt;
                r_push  <= w_push_nxt;
                r_dpush <= w_dpush_nxt;
            end
        end

        assign pop[b]    = r_pop;
        assign push[b]   = r_push;
        assign D_push[b] = r_dpush;
    end

endmodule
`default_nettype wire

// File: tb/tb_bs_gnrtr_n_rbtr.sv
`default_nettype none
// ============================================================================
// Module   : tb_bs_gnrtr_n_rbtr
// Purpose  : Directed and random checks of bs_gnrtr_n_rbtr against a
//            packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bs_gnrtr_n_rbtr;

    localparam int         BITS      = 2;
    localparam int         DRVRS     = 5;
    localparam int         PCKG_SZ   = 16;
    localparam logic [7:0] BROADCAST = 8'h8F;

    logic                                   clk = 1'b0;
    logic                                   reset;
    logic [BITS-1:0][DRVRS-1:0]              pndng;
    logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_pop;
    logic [BITS-1:0][DRVRS-1:0]              pop;
    logic [BITS-1:0][DRVRS-1:0]              push;
    logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_push;

    bs_gnrtr_n_rbtr #(
        .BITS(BITS), .DRVRS(DRVRS), .PCKG_SZ(PCKG_SZ), .BROADCAST(BROADCAST)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: each bus is either free to pick a packet or holding
    // one that it delivers on the following edge.
    bit                         m_busy  [BITS];
    int                         m_last  [BITS];
    int                         m_src   [BITS];
    logic [PCKG_SZ-1:0]         m_pkt   [BITS];
    logic [DRVRS-1:0]           e_pop   [BITS];
    logic [DRVRS-1:0]           e_push  [BITS];
    logic [DRVRS*PCKG_SZ-1:0]   e_dpush [BITS];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int b = 0; b < BITS; b++) begin
            if (reset) begin
                m_busy[b]  = 1'b0;
                m_last[b]  = DRVRS - 1;
                e_pop[b]   = '0;
                e_push[b]  = '0;
                e_dpush[b] = '0;
            end else begin
                e_pop[b]  = '0;
                e_push[b] = '0;
                if (m_busy[b]) begin
                    int dest;
                    dest = int'(m_pkt[b][PCKG_SZ-1 -: 8]);
                    for (int d = 0; d < DRVRS; d++) begin
                        if (dest == int'(BROADCAST)) e_push[b][d] = (d != m_src[b]);
                        else                         e_push[b][d] = (d == dest) && (d != m_src[b]);
                    end
                    e_dpush[b] = {DRVRS{m_pkt[b]}};
                    m_last[b]  = m_src[b];
                    m_busy[b]  = 1'b0;
                end else begin
                    for (int k = 1; k <= DRVRS; k++) begin
                        int d;
                        d = (m_last[b] + k) % DRVRS;
                        if (!m_busy[b] && pndng[b][d]) begin
                            m_busy[b]   = 1'b1;
                            m_src[b]    = d;
                            m_pkt[b]    = D_pop[b][d];
                            e_pop[b][d] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        for (int b = 0; b < BITS; b++) begin
            chk($sformatf("pop[%0d]", b),    128'(pop[b]),    128'(e_pop[b]));
            chk($sformatf("push[%0d]", b),   128'(push[b]),   128'(e_push[b]));
            chk($sformatf("D_push[%0d]", b), 128'(D_push[b]), 128'(e_dpush[b]));
        end
    endtask

    function automatic logic [PCKG_SZ-1:0] rand_pkt();
        int  r;
        logic [7:0] hdr;
        r = $urandom_range(0, 9);
        if (r < 5)       hdr = 8'(r);
        else if (r == 5) hdr = BROADCAST;
        else if (r == 6) hdr = 8'd7;
        else             hdr = 8'($urandom);
        return {hdr, 8'($urandom)};
    endfunction

    int grants[$];
    int gcyc[$];

    initial begin
        reset = 1'b1;
        pndng = '1;
        for (int b = 0; b < BITS; b++)
            for (int d = 0; d < DRVRS; d++) D_pop[b][d] = rand_pkt();

        // Reset held for two cycles with every device pending
        cycle();
        cycle();
        chk("reset_pop",   128'(pop),    128'(0));
        chk("reset_push",  128'(push),   128'(0));
        chk("reset_dpush", 128'(D_push), 128'(0));

        // First grant after release goes to device 0
        reset = 1'b0;
        pndng[1] = '0;
        D_pop[0][0] = 16'h0100;
        cycle();
        chk("first_grant", 128'(pop[0]), 128'(5'b00001));
        pndng = '0;
        cycle();
        chk("first_push", 128'(push[0]), 128'(5'b00010));
        cycle();

        // Unicast device 1 -> device 3
        pndng[0] = 5'b00010;
        D_pop[0][1] = 16'h03AB;
        cycle();
        chk("uni_pop", 128'(pop[0]), 128'(5'b00010));
        pndng = '0;
        cycle();
        chk("uni_pop_off", 128'(pop[0]),  128'(0));
        chk("uni_push",    128'(push[0]), 128'(5'b01000));
        chk("uni_data",    128'(D_push[0][3]), 128'(16'h03AB));
        cycle();
        chk("uni_push_off", 128'(push[0]), 128'(0));
        chk("uni_data_hold", 128'(D_push[0][3]), 128'(16'h03AB));

        // Broadcast from device 2
        pndng[0] = 5'b00100;
        D_pop[0][2] = 16'h8F55;
        cycle();
        pndng = '0;
        cycle();
        chk("bc_push", 128'(push[0]), 128'(5'b11011));
        for (int d = 0; d < DRVRS; d++)
            chk($sformatf("bc_lane%0d", d), 128'(D_push[0][d]), 128'(16'h8F55));
        cycle();

        // Invalid ID from device 0, then self-addressed from device 4
        pndng[0] = 5'b00001;
        D_pop[0][0] = 16'h0711;
        cycle();
        chk("inv_pop", 128'(pop[0]), 128'(5'b00001));
        pndng = '0;
        cycle();
        chk("inv_push", 128'(push[0]), 128'(0));
        pndng[0] = 5'b10000;
        D_pop[0][4] = 16'h0422;
        cycle();
        chk("self_pop", 128'(pop[0]), 128'(5'b10000));
        pndng = '0;
        cycle();
        chk("self_push", 128'(push[0]), 128'(0));
        cycle();

        // Round-robin fairness from a fresh reset
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        pndng[0] = '1;
        for (int i = 0; i < 12; i++) begin
            D_pop[0][i % DRVRS] = rand_pkt();
            cycle();
            for (int d = 0; d < DRVRS; d++)
                if (pop[0][d]) begin
                    grants.push_back(d);
                    gcyc.push_back(cyc);
                end
        end
        chk("rr_count", 128'(grants.size()), 128'(6));
        if (grants.size() >= 6) begin
            for (int i = 0; i < 6; i++)
                chk($sformatf("rr_grant%0d", i), 128'(grants[i]), 128'(i % DRVRS));
            for (int i = 0; i < 5; i++)
                chk($sformatf("rr_gap%0d", i), 128'(gcyc[i+1] - gcyc[i]), 128'(2));
        end

        // Reset during the SEND cycle
        pndng = '0;
        cycle();
        cycle();
        pndng[0] = 5'b00100;
        D_pop[0][2] = 16'h0012;
        cycle();
        chk("mid_pop", 128'(pop[0]), 128'(5'b00100));
        reset = 1'b1;
        pndng = '0;
        cycle();
        chk("mid_push",  128'(push),   128'(0));
        chk("mid_pop0",  128'(pop),    128'(0));
        chk("mid_dpush", 128'(D_push), 128'(0));
        reset = 1'b0;
        pndng[0] = '1;
        cycle();
        chk("mid_restart", 128'(pop[0]), 128'(5'b00001));

        // Random traffic on both buses
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int b = 0; b < BITS; b++)
                for (int d = 0; d < DRVRS; d++) begin
                    pndng[b][d] = ($urandom_range(0, 2) != 0);
                    D_pop[b][d] = rand_pkt();
                end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
